// File: rtl/store_pkg.sv
// Shared encodings for the narrowing store path: access sizes, FSM states, lane helpers.
package store_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_MERGE = 3'd2;
    localparam logic [2:0] ST_WR    = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    // A byte lane index shifted left by this many bits gives its bit offset in the word.
    localparam int LANE_BITS = 3;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Replaces the addressed byte lanes of a memory word with store data.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Lane choice follows the configured byte order; unaddressed lanes pass through untouched.
module byte_lane_merge
    import store_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);

    logic [1:0]  lane;
    logic [4:0]  shamt;
    logic [31:0] mask;
    logic [31:0] ins;

    always_comb begin
        lane = BIG_ENDIAN ? ~addr_lo : addr_lo;
        // Halfwords occupy an even lane pair; bit 0 only matters for bytes.
        if (size == SIZE_HALF) begin
            lane[0] = 1'b0;
        end
        shamt = {3'b000, lane} << LANE_BITS;
        case (size)
            SIZE_BYTE: begin
                mask = 32'h0000_00ff << shamt;
                ins  = {24'h0, data[7:0]} << shamt;
            end
            SIZE_HALF: begin
                mask = 32'h0000_ffff << shamt;
                ins  = {16'h0, data[15:0]} << shamt;
            end
            default: begin
                mask = 32'hffff_ffff;
                ins  = data;
            end
        endcase
        merged = (old_word & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/store_merge_unit.sv
// Narrowing store unit: SB/SH via read-modify-write on a word RAM without byte enables, SW direct.
// Latency: accept->MemWrite 1 cycle for words, 3 cycles for byte/half; misaligned pulses after 1.
// Backpressure: Ready only in IDLE; a held StoreReq is re-sampled once the operation retires.
module store_merge_unit
    import store_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  StoreReq,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [31:0]           StoreData,
    input  logic [1:0]            Size,
    output logic                  Ready,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic                  MemRead,
    input  logic [31:0]           MemReadData,
    output logic                  MemWrite,
    output logic [31:0]           MemWriteData,
    output logic                  Done,
    output logic                  Misaligned
);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic [1:0]            size_q;
    logic [31:0]           wdata_q;
    logic [31:0]           merged;

    byte_lane_merge #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_merge (
        .old_word(MemReadData),
        .data    (data_q),
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .merged  (merged)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= SIZE_BYTE;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (StoreReq) begin
                        addr_q <= Addr;
                        data_q <= StoreData;
                        size_q <= Size;
                        if (is_misaligned(Size, Addr[1:0])) begin
                            state <= ST_ERR;
                        end else if (Size == SIZE_WORD) begin
                            wdata_q <= StoreData;
                            state   <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD:    state <= ST_MERGE;
                // MemReadData is valid here, one cycle after the read strobe.
                ST_MERGE: begin
                    wdata_q <= merged;
                    state   <= ST_WR;
                end
                ST_WR:    state <= ST_IDLE;
                ST_ERR:   state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign Ready        = (state == ST_IDLE);
    assign MemRead      = (state == ST_RD);
    assign MemWrite     = (state == ST_WR);
    assign Done         = (state == ST_WR);
    assign Misaligned   = (state == ST_ERR);
    assign MemAddr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign MemWriteData = wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: little- and big-endian instances share stimulus, each with its own word RAM.
module tb_store_merge_unit;
    import store_pkg::*;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        Reset, StoreReq;
    logic [31:0] Addr, StoreData;
    logic [1:0]  Size;

    logic        le_ready, le_rd, le_wr, le_done, le_mis;
    logic [31:0] le_maddr, le_wdat, le_rdat;
    logic        be_ready, be_rd, be_wr, be_done, be_mis;
    logic [31:0] be_maddr, be_wdat, be_rdat;

    store_merge_unit #(.ADDR_WIDTH(32), .BIG_ENDIAN(1'b0)) dut_le (
        .CLK(CLK), .Reset(Reset), .StoreReq(StoreReq), .Addr(Addr), .StoreData(StoreData),
        .Size(Size), .Ready(le_ready), .MemAddr(le_maddr), .MemRead(le_rd),
        .MemReadData(le_rdat), .MemWrite(le_wr), .MemWriteData(le_wdat), .Done(le_done),
        .Misaligned(le_mis)
    );

    store_merge_unit #(.ADDR_WIDTH(32), .BIG_ENDIAN(1'b1)) dut_be (
        .CLK(CLK), .Reset(Reset), .StoreReq(StoreReq), .Addr(Addr), .StoreData(StoreData),
        .Size(Size), .Ready(be_ready), .MemAddr(be_maddr), .MemRead(be_rd),
        .MemReadData(be_rdat), .MemWrite(be_wr), .MemWriteData(be_wdat), .Done(be_done),
        .Misaligned(be_mis)
    );

    // Synchronous word RAMs covering byte addresses 0x100..0x1FF, plus a preload port.
    logic [31:0] mem_le [0:63];
    logic [31:0] mem_be [0:63];
    logic        pl_vld;
    logic [5:0]  pl_idx;
    logic [31:0] pl_dat;

    always @(posedge CLK) begin
        if (pl_vld) begin
            mem_le[pl_idx] <= pl_dat;
            mem_be[pl_idx] <= pl_dat;
        end
        if (le_wr) mem_le[le_maddr[7:2]] <= le_wdat;
        if (be_wr) mem_be[be_maddr[7:2]] <= be_wdat;
        if (le_rd) le_rdat <= mem_le[le_maddr[7:2]];
        if (be_rd) be_rdat <= mem_be[be_maddr[7:2]];
    end

    int wr_cnt   = 0;
    bit overlap  = 1'b0;
    bit sync_bad = 1'b0;

    always @(negedge CLK) begin
        if (!Reset) begin
            wr_cnt <= wr_cnt + int'(le_wr);
            if ((le_rd && le_wr) || (be_rd && be_wr)) overlap <= 1'b1;
            if ({le_ready, le_rd, le_wr, le_mis, le_maddr} != {be_ready, be_rd, be_wr, be_mis, be_maddr} ||
                le_done != le_wr || be_done != be_wr)
                sync_bad <= 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;
    int exp_wr_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: view the word as four byte addresses, store bytes by address, repack.
    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] s, input logic [1:0] a, input bit be);
        logic [7:0]  b [4];
        logic [31:0] r;
        int n;
        for (int k = 0; k < 4; k++) b[k] = be ? old[8*(3-k) +: 8] : old[8*k +: 8];
        n = (s == SIZE_BYTE) ? 1 : (s == SIZE_HALF) ? 2 : 4;
        for (int i = 0; i < n; i++) b[int'(a) + i] = be ? d[8*(n-1-i) +: 8] : d[8*i +: 8];
        r = '0;
        for (int k = 0; k < 4; k++) begin
            if (be) r[8*(3-k) +: 8] = b[k];
            else    r[8*k +: 8]     = b[k];
        end
        return r;
    endfunction

    function automatic bit ref_mis(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_vld = 1'b1;
        pl_idx = a[7:2];
        pl_dat = d;
        @(posedge CLK); #1;
        pl_vld = 1'b0;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         input logic [31:0] pre, input logic [31:0] exp_le, input logic [31:0] exp_be,
                         input string tag);
        int rd_lat, wr_lat, mis_lat, back, nrd, nwr;
        int e_rd, e_wr, e_mis, e_back;
        logic [31:0] wd_le, wd_be, waddr;
        bit mis;
        rd_lat = -1; wr_lat = -1; mis_lat = -1; back = -1; nrd = 0; nwr = 0;
        wd_le = '0; wd_be = '0; waddr = '0;
        preload(a, pre);
        chk({tag, " ready_before"}, 32'(le_ready), 32'd1);
        Addr = a; StoreData = d; Size = s; StoreReq = 1'b1;
        @(posedge CLK); #1;
        // Garbage on the inputs while busy must not leak into the operation.
        StoreReq = 1'b0; Addr = $urandom; StoreData = $urandom; Size = 2'($urandom);
        for (int k = 1; k <= 8; k++) begin
            if (le_rd) begin rd_lat = k; nrd++; end
            if (le_wr) begin wr_lat = k; nwr++; wd_le = le_wdat; wd_be = be_wdat; waddr = le_maddr; end
            if (le_mis) mis_lat = k;
            if (le_ready) begin back = k; break; end
            @(posedge CLK); #1;
        end
        mis = ref_mis(s, a);
        if (mis)                 begin e_rd = -1; e_wr = -1; e_mis = 1;  e_back = 2; end
        else if (s == SIZE_WORD) begin e_rd = -1; e_wr = 1;  e_mis = -1; e_back = 2; end
        else                     begin e_rd = 1;  e_wr = 3;  e_mis = -1; e_back = 4; end
        chk({tag, " read_lat"},   32'(rd_lat),  32'(e_rd));
        chk({tag, " write_lat"},  32'(wr_lat),  32'(e_wr));
        chk({tag, " misal_lat"},  32'(mis_lat), 32'(e_mis));
        chk({tag, " ready_back"}, 32'(back),    32'(e_back));
        chk({tag, " n_reads"},    32'(nrd),     (e_rd < 0) ? 32'd0 : 32'd1);
        chk({tag, " n_writes"},   32'(nwr),     mis ? 32'd0 : 32'd1);
        if (!mis) begin
            exp_wr_total++;
            chk({tag, " wdata_le"}, wd_le, exp_le);
            chk({tag, " wdata_be"}, wd_be, exp_be);
            chk({tag, " mem_addr"}, waddr, {a[31:2], 2'b00});
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] pre;
        logic [31:0] exp_le;
        logic [31:0] exp_be;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [9:0]  acc_mask;
        int          dn, w0;
        logic [31:0] ra, rd, rp;
        logic [1:0]  rs;

        vecs[0] = '{32'h100, 32'hDEADBEEF, SIZE_WORD, 32'h0000_0000, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{32'h103, 32'h123456AB, SIZE_BYTE, 32'h1122_3344, 32'hAB223344, 32'h112233AB};
        vecs[2] = '{32'h102, 32'hFFFFCAFE, SIZE_HALF, 32'h0000_0000, 32'hCAFE0000, 32'h0000CAFE};
        vecs[3] = '{32'h101, 32'h0000BEEF, SIZE_HALF, 32'h5555_5555, 32'h0, 32'h0};
        vecs[4] = '{32'h102, 32'hCAFEF00D, SIZE_WORD, 32'h5555_5555, 32'h0, 32'h0};
        vecs[5] = '{32'h100, 32'hCAFEF00D, SIZE_RSVD, 32'h5555_5555, 32'h0, 32'h0};
        vecs[6] = '{32'h110, 32'hFFFFFF00, SIZE_BYTE, 32'hFFFF_FFFF, 32'hFFFFFF00, 32'h00FFFFFF};
        vecs[7] = '{32'h114, 32'h0000BEEF, SIZE_HALF, 32'h1122_3344, 32'h1122BEEF, 32'hBEEF3344};
        vecs[8] = '{32'h119, 32'hAAAAAA55, SIZE_BYTE, 32'h1122_3344, 32'h11225544, 32'h11553344};

        Reset = 1'b1; StoreReq = 1'b0; Addr = '0; StoreData = '0; Size = '0;
        pl_vld = 1'b0; pl_idx = '0; pl_dat = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset ready",  32'(le_ready),   32'd1);
        chk("reset strobes", {28'h0, le_rd, le_wr, le_done, le_mis}, 32'h0);
        chk("reset memaddr", le_maddr, 32'h0);
        chk("reset wdata",   le_wdat,  32'h0);
        Reset = 1'b0;

        for (int i = 0; i < 9; i++)
            do_op(vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].pre,
                  vecs[i].exp_le, vecs[i].exp_be, $sformatf("vec%0d", i));

        // Reset while the byte store sits in MERGE: dropped, no write afterwards.
        preload(32'h104, 32'h0);
        Addr = 32'h104; StoreData = 32'h77; Size = SIZE_BYTE; StoreReq = 1'b1;
        @(posedge CLK); #1;
        StoreReq = 1'b0;
        chk("rst_mid read_strobe", 32'(le_rd), 32'd1);
        @(posedge CLK); #1;
        chk("rst_mid busy", {30'h0, le_ready, le_wr}, 32'h0);
        Reset = 1'b1;
        w0 = wr_cnt;
        @(posedge CLK); #1;
        Reset = 1'b0;
        chk("rst_mid ready", 32'(le_ready), 32'd1);
        chk("rst_mid strobes", {28'h0, le_rd, le_wr, le_done, le_mis}, 32'h0);
        chk("rst_mid wdata", le_wdat, 32'h0);
        repeat (5) @(posedge CLK);
        #1;
        chk("rst_mid no_write", 32'(wr_cnt), 32'(w0));

        // StoreReq held for 10 cycles: accepts land every 4 cycles, Ready low in between.
        preload(32'h108, 32'hFFFF_FFFF);
        Addr = 32'h109; StoreData = 32'h1234_565A; Size = SIZE_BYTE; StoreReq = 1'b1;
        acc_mask = '0; dn = 0;
        for (int i = 0; i < 10; i++) begin
            if (le_ready) acc_mask[i] = 1'b1;
            if (le_done) dn++;
            @(posedge CLK); #1;
        end
        StoreReq = 1'b0;
        chk("held accept_pattern", 32'(acc_mask), 32'h111);
        chk("held done_in_window", 32'(dn), 32'd2);
        for (int k = 0; k < 8; k++) begin
            if (le_done) dn++;
            if (le_ready) break;
            @(posedge CLK); #1;
        end
        exp_wr_total += 3;
        chk("held done_total", 32'(dn), 32'd3);
        chk("held wdata_le", le_wdat, ref_merge(32'hFFFF_FFFF, 32'h5A, SIZE_BYTE, 2'd1, 1'b0));

        for (int i = 0; i < 40; i++) begin
            ra = 32'h100 + 32'($urandom_range(0, 255));
            rd = $urandom;
            rp = $urandom;
            rs = 2'($urandom_range(0, 3));
            do_op(ra, rd, rs, rp, ref_merge(rp, rd, rs, ra[1:0], 1'b0),
                  ref_merge(rp, rd, rs, ra[1:0], 1'b1), $sformatf("rnd%0d", i));
        end

        @(posedge CLK); #1;
        chk("no read/write overlap", 32'(overlap), 32'd0);
        chk("le/be strobe agreement", 32'(sync_bad), 32'd0);
        chk("total writes", 32'(wr_cnt), 32'(exp_wr_total));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
